// File: rtl/sram_like_responder.sv
// Slave model of the sram-like bus: word RAM behind a small in-order response queue.
// Writes land in the RAM at acceptance; every accepted request gets one data_ok after LATENCY cycles.
module sram_like_responder #(
    parameter int ADDR_W    = 16,
    parameter int LATENCY   = 1,
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        resp_hold
);

    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTST);
    localparam logic [3:0]       INIT_DELAY = 4'(LATENCY - 1);

    typedef struct packed {
        logic        is_write;
        logic [31:0] data;
        logic [3:0]  delay;
    } entry_t;

    logic [31:0]       mem [2**ADDR_W];
    entry_t            queue [MAX_OUTST];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  cnt;
    logic              resetn_q;
    logic [ADDR_W-1:0] word_idx;
    logic              push;
    logic              pop;
    logic              unused_ok;

    assign word_idx  = addr[ADDR_W+1:2];
    assign unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // addr_ok looks only at registered state, so a same-cycle pop never re-opens the slot early.
    always_comb begin
        addr_ok = resetn_q && (cnt < FULL_CNT);
        data_ok = (cnt != '0) && (queue[head].delay == 4'd0) && !resp_hold;
        rdata   = (data_ok && !queue[head].is_write) ? queue[head].data : 32'd0;
        push    = req && addr_ok && resetn;
        pop     = data_ok;
    end

    always_ff @(posedge clk) begin
        resetn_q <= resetn;
        if (!resetn) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // NOTE: queue payload and RAM carry no reset; cnt alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTST; i++) begin
            if (queue[i].delay != 4'd0)
                queue[i].delay <= queue[i].delay - 4'd1;
        end
        if (push)
            queue[tail] <= '{is_write: wr, data: (wr ? 32'd0 : mem[word_idx]), delay: INIT_DELAY};
    end

    always_ff @(posedge clk) begin
        if (push && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: three instances with different latency/depth
// share the request fields; each has its own req and resp_hold.
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_a, req_b, req_c;
    logic        hold_a, hold_b, hold_c;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok_a, addr_ok_b, addr_ok_c;
    logic        data_ok_a, data_ok_b, data_ok_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic        LAT_WR  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [31:0] LAT_WD  [4] = '{32'h0, 32'h5A5A0002, 32'h0, 32'h0};
    localparam logic        LAT_OK  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [31:0] LAT_RD  [8] = '{32'h0, 32'h0, 32'h0, 32'hA5A50001,
                                            32'h0, 32'h5A5A0002, 32'h5A5A0002, 32'h0};

    always #5 clk = ~clk;

    sram_like_responder #(.ADDR_W(8), .LATENCY(1), .MAX_OUTST(4)) dut_a (
        .clk(clk), .resetn(resetn), .req(req_a), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok_a), .data_ok(data_ok_a),
        .rdata(rdata_a), .resp_hold(hold_a)
    );

    sram_like_responder #(.ADDR_W(8), .LATENCY(3), .MAX_OUTST(4)) dut_b (
        .clk(clk), .resetn(resetn), .req(req_b), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok_b), .data_ok(data_ok_b),
        .rdata(rdata_b), .resp_hold(hold_b)
    );

    sram_like_responder #(.ADDR_W(8), .LATENCY(2), .MAX_OUTST(3)) dut_c (
        .clk(clk), .resetn(resetn), .req(req_c), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok_c), .data_ok(data_ok_c),
        .rdata(rdata_c), .resp_hold(hold_c)
    );

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        wr    = w;
        addr  = a;
        wdata = d;
        wstrb = s;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        {req_a, req_b, req_c}    = 3'b000;
        {hold_a, hold_b, hold_c} = 3'b000;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({addr_ok_a, addr_ok_b, addr_ok_c} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_addr_ok_first: got %b expected 000", {addr_ok_a, addr_ok_b, addr_ok_c});
        end
        n_cmp++;
        if ({data_ok_a, data_ok_b, data_ok_c} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_data_ok: got %b expected 000", {data_ok_a, data_ok_b, data_ok_c});
        end
        n_cmp++;
        if ({rdata_a, rdata_b, rdata_c} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h expected 0", {rdata_a, rdata_b, rdata_c});
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({addr_ok_a, addr_ok_b, addr_ok_c} !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_addr_ok_second: got %b expected 111", {addr_ok_a, addr_ok_b, addr_ok_c});
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        req_a = 1'b1;
        drive(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        n_cmp++;
        if (addr_ok_a !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_accept: got %b expected 1", addr_ok_a);
        end
        next_cycle();
        drive(1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        n_cmp++;
        if (data_ok_a !== 1'b1 || rdata_a !== 32'h0) begin
            n_bad++;
            $display("FAIL wr_response: got data_ok=%b rdata=%h expected 1/00000000", data_ok_a, rdata_a);
        end
        next_cycle();
        req_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (data_ok_a !== 1'b1 || rdata_a !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL rd_response: got data_ok=%b rdata=%h expected 1/deadbeef", data_ok_a, rdata_a);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (data_ok_a !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_idle_after: got %b expected 0", data_ok_a);
        end
        next_cycle();
    endtask

    task automatic test_partial_write();
        req_a = 1'b1;
        drive(1'b1, 32'h20, 32'h11223344, 4'hF);
        next_cycle();
        drive(1'b1, 32'h20, 32'h0000AA00, 4'h2);
        next_cycle();
        drive(1'b0, 32'h20, 32'h0, 4'h0);
        next_cycle();
        req_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (data_ok_a !== 1'b1 || rdata_a !== 32'h1122AA44) begin
            n_bad++;
            $display("FAIL partial_write: got data_ok=%b rdata=%h expected 1/1122aa44", data_ok_a, rdata_a);
        end
        next_cycle();
    endtask

    task automatic test_full_hold();
        int acc = 0;
        hold_a = 1'b1;
        req_a  = 1'b1;
        drive(1'b0, 32'h10, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            addr = (acc % 2 == 1) ? 32'h20 : 32'h10;
            @(negedge clk);
            n_cmp++;
            if (addr_ok_a !== (k < 4) || data_ok_a !== 1'b0) begin
                n_bad++;
                $display("FAIL full_hold_fill cycle %0d: got addr_ok=%b data_ok=%b expected %b/0",
                         k, addr_ok_a, data_ok_a, (k < 4));
            end
            if (req_a && addr_ok_a) acc++;
            next_cycle();
        end
        n_cmp++;
        if (acc != 4) begin
            n_bad++;
            $display("FAIL full_hold_accepts: got %0d expected 4", acc);
        end
        req_a  = 1'b0;
        hold_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] exp_rd;
            exp_rd = (k >= 4) ? 32'h0 : ((k % 2 == 1) ? 32'h1122AA44 : 32'hDEADBEEF);
            @(negedge clk);
            n_cmp++;
            if (data_ok_a !== (k < 4) || rdata_a !== exp_rd || addr_ok_a !== (k != 0)) begin
                n_bad++;
                $display("FAIL full_hold_drain cycle %0d: got data_ok=%b rdata=%h addr_ok=%b expected %b/%h/%b",
                         k, data_ok_a, rdata_a, addr_ok_a, (k < 4), exp_rd, (k != 0));
            end
            next_cycle();
        end
    endtask

    task automatic test_latency();
        req_b = 1'b1;
        drive(1'b1, 32'h40, 32'hA5A50001, 4'hF);
        next_cycle();
        req_b = 1'b0;
        repeat (4) next_cycle();
        for (int j = 0; j < 8; j++) begin
            if (j < 4) begin
                req_b = 1'b1;
                drive(LAT_WR[j], 32'h40, LAT_WD[j], 4'hF);
            end else begin
                req_b = 1'b0;
            end
            @(negedge clk);
            if (j < 4) begin
                n_cmp++;
                if (addr_ok_b !== 1'b1) begin
                    n_bad++;
                    $display("FAIL latency_accept cycle %0d: got %b expected 1", j, addr_ok_b);
                end
            end
            n_cmp++;
            if (data_ok_b !== LAT_OK[j] || rdata_b !== LAT_RD[j]) begin
                n_bad++;
                $display("FAIL latency_resp cycle %0d: got data_ok=%b rdata=%h expected %b/%h",
                         j, data_ok_b, rdata_b, LAT_OK[j], LAT_RD[j]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        hold_a = 1'b1;
        req_a  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h50 + 32'(4 * k), 32'h0BAD0050 + 32'(4 * k), 4'hF);
            next_cycle();
        end
        req_a  = 1'b0;
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        hold_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (data_ok_a !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid_flush cycle %0d: got data_ok=%b expected 0", k, data_ok_a);
            end
            next_cycle();
        end
        req_a = 1'b1;
        drive(1'b0, 32'h54, 32'h0, 4'h0);
        @(negedge clk);
        n_cmp++;
        if (addr_ok_a !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_accept: got %b expected 1", addr_ok_a);
        end
        next_cycle();
        req_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (data_ok_a !== 1'b1 || rdata_a !== 32'h0BAD0054) begin
            n_bad++;
            $display("FAIL reset_mid_ram_kept: got data_ok=%b rdata=%h expected 1/0bad0054", data_ok_a, rdata_a);
        end
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_q[$];
        logic [31:0] d;
        int item  = 0;
        int acc   = 0;
        int resp  = 0;
        int guard = 0;
        while ((item < 20 || exp_q.size() != 0) && guard < 400) begin
            hold_c = 1'($urandom_range(0, 1));
            d = 32'hC0DE0000 + 32'(item / 2) * 32'h0101;
            if (item < 20) begin
                req_c = 1'b1;
                if (item % 2 == 0) drive(1'b1, 32'h80 + 32'(8 * (item / 2)), d, 4'hF);
                else               drive(1'b0, 32'h80 + 32'(8 * (item / 2)), 32'h0, 4'h0);
            end else begin
                req_c = 1'b0;
            end
            @(negedge clk);
            if (data_ok_c) begin
                resp++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wrap_unexpected_resp: got data_ok=1 rdata=%h expected no response", rdata_c);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (rdata_c !== e) begin
                        n_bad++;
                        $display("FAIL wrap_rdata resp %0d: got %h expected %h", resp, rdata_c, e);
                    end
                end
            end
            if (req_c && addr_ok_c) begin
                exp_q.push_back((item % 2 == 1) ? d : 32'h0);
                item++;
                acc++;
            end
            next_cycle();
            guard++;
        end
        req_c  = 1'b0;
        hold_c = 1'b0;
        n_cmp++;
        if (guard >= 400) begin
            n_bad++;
            $display("FAIL wrap_timeout: got %0d accepts %0d queued expected 20/0", acc, exp_q.size());
        end
        n_cmp++;
        if (acc != 20 || resp != acc) begin
            n_bad++;
            $display("FAIL wrap_counts: got accepts=%0d responses=%0d expected 20/20", acc, resp);
        end
    endtask

    initial begin
        size = 2'd2;
        test_reset();
        test_write_read();
        test_partial_write();
        test_full_hold();
        test_latency();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
